ga_issue_ctrl: RTL

Sequencer between the Ibex decode/issue point and the GA coprocessor datapath. It accepts custom-0..3 instructions one at a time and decodes opcode and funct3. Datapath operations (custom-0/1/2) are dispatched to the GA ALU over a req/ack/done handshake, and results return to the core register-file writeback port. Control/status operations (custom-3) are executed locally: enable, disable, reset, flush, config and status.

---
 rtl/ga_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ga_issue_ctrl.sv
// GA coprocessor issue sequencer: decodes custom-0..3, dispatches datapath ops over req/ack/done and
// runs custom-3 control ops locally. Optional watchdog enabled by defining GA_ISSUE_TIMEOUT_EN.
module ga_issue_ctrl #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [DataWidth-1:0] rs1_i,
  input  logic [DataWidth-1:0] rs2_i,
  output logic                 ga_req_o,
  output logic [1:0]           ga_cls_o,
  output logic [2:0]           ga_funct3_o,
  output logic [DataWidth-1:0] ga_op_a_o,
  output logic [DataWidth-1:0] ga_op_b_o,
  input  logic                 ga_ack_i,
  input  logic                 ga_done_i,
  input  logic [DataWidth-1:0] ga_result_i,
  output logic                 ga_flush_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           wb_rd_o,
  output logic [DataWidth-1:0] wb_data_o,
  output logic                 illegal_o,
  output logic                 busy_o,
  output logic                 enabled_o,
  output logic                 timeout_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
  localparam logic [6:0] OPC_CUSTOM2 = 7'h5B;
  localparam logic [6:0] OPC_CUSTOM3 = 7'h7B;

  localparam logic [2:0] F3_CONFIG  = 3'b000;
  localparam logic [2:0] F3_STATUS  = 3'b001;
  localparam logic [2:0] F3_RESET   = 3'b010;
  localparam logic [2:0] F3_ENABLE  = 3'b011;
  localparam logic [2:0] F3_DISABLE = 3'b100;
  localparam logic [2:0] F3_FLUSH   = 3'b101;

  // Class code carried to the ALU alongside the dispatched op.
  function automatic logic [1:0] opc_class(input logic [6:0] opc);
    logic [1:0] cls;
    cls = 2'd0;
    if (opc == OPC_CUSTOM1) cls = 2'd1;
    if (opc == OPC_CUSTOM2) cls = 2'd2;
    return cls;
  endfunction

  // custom-1 and custom-2 reserve funct3 110/111; custom-0 uses the full space.
  function automatic logic dp_f3_illegal(input logic [6:0] opc, input logic [2:0] f3);
    return ((opc == OPC_CUSTOM1) || (opc == OPC_CUSTOM2)) && (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [DataWidth-1:0] status_word(input logic ill, input logic tmo,
                                                       input logic en);
    logic [DataWidth-1:0] w;
    w      = '0;
    w[2:0] = {ill, tmo, en};
    return w;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       accept;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign rd                = instr_i[11:7];
  assign funct3            = instr_i[14:12];
  assign unused_instr_bits = ^instr_i[31:15];

  logic [1:0]           state_q, state_d;
  logic                 enabled_q, enabled_d;
  logic [DataWidth-1:0] cfg_q, cfg_d;
  logic                 ill_sticky_q, ill_sticky_d;
  logic                 tmo_sticky_q, tmo_sticky_d;
  logic [1:0]           cls_q, cls_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [4:0]           rd_q, rd_d;
  logic [DataWidth-1:0] op_a_q, op_a_d;
  logic [DataWidth-1:0] op_b_q, op_b_d;
  logic [DataWidth-1:0] wb_data_q, wb_data_d;
  logic                 illegal_p1, illegal_d;
  logic                 flush_p1, flush_d;
  logic                 timeout_p1, timeout_d;
  logic                 tmo_hit;

  assign accept = instr_valid_i && (state_q == ST_IDLE);

`ifdef GA_ISSUE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles) + 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] tmo_cnt_q;

  // Counter is 0 in the first ISSUE cycle, so the limit is hit in the TimeoutCycles-th busy cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end

  assign tmo_hit = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (tmo_cnt_q == TmoLast);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    enabled_d    = enabled_q;
    cfg_d        = cfg_q;
    ill_sticky_d = ill_sticky_q;
    tmo_sticky_d = tmo_sticky_q;
    cls_d        = cls_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    wb_data_d    = wb_data_q;
    illegal_d    = 1'b0;
    flush_d      = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d = funct3;
          rd_d     = rd;
          op_a_d   = rs1_i;
          op_b_d   = rs2_i;
          case (opcode)
            OPC_CUSTOM0, OPC_CUSTOM1, OPC_CUSTOM2: begin
              if (!enabled_q || dp_f3_illegal(opcode, funct3)) begin
                illegal_d    = 1'b1;
                ill_sticky_d = 1'b1;
              end else begin
                cls_d   = opc_class(opcode);
                state_d = ST_ISSUE;
              end
            end
            OPC_CUSTOM3: begin
              case (funct3)
                F3_CONFIG: begin
                  cfg_d     = rs1_i;
                  wb_data_d = cfg_q;
                  state_d   = ST_WB;
                end
                F3_STATUS: begin
                  wb_data_d = status_word(ill_sticky_q, tmo_sticky_q, enabled_q);
                  state_d   = ST_WB;
                end
                F3_RESET: begin
                  enabled_d    = 1'b0;
                  cfg_d        = '0;
                  ill_sticky_d = 1'b0;
                  tmo_sticky_d = 1'b0;
                  flush_d      = 1'b1;
                end
                F3_ENABLE:  enabled_d = 1'b1;
                F3_DISABLE: enabled_d = 1'b0;
                F3_FLUSH:   flush_d   = 1'b1;
                default: begin
                  illegal_d    = 1'b1;
                  ill_sticky_d = 1'b1;
                end
              endcase
            end
            default: begin
              illegal_d    = 1'b1;
              ill_sticky_d = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        // A done together with the ack completes directly and also beats the watchdog.
        if (ga_ack_i && ga_done_i) begin
          wb_data_d = ga_result_i;
          state_d   = (rd_q == 5'd0) ? ST_IDLE : ST_WB;
        end else if (tmo_hit) begin
          flush_d      = 1'b1;
          timeout_d    = 1'b1;
          tmo_sticky_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (ga_ack_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ga_done_i) begin
          wb_data_d = ga_result_i;
          state_d   = (rd_q == 5'd0) ? ST_IDLE : ST_WB;
        end else if (tmo_hit) begin
          flush_d      = 1'b1;
          timeout_d    = 1'b1;
          tmo_sticky_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WB: begin
        if (wb_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered stage: every output-visible register clears so the block powers up quiet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      enabled_q    <= 1'b0;
      cfg_q        <= '0;
      ill_sticky_q <= 1'b0;
      tmo_sticky_q <= 1'b0;
      cls_q        <= 2'd0;
      funct3_q     <= 3'd0;
      rd_q         <= 5'd0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      wb_data_q    <= '0;
      illegal_p1   <= 1'b0;
      flush_p1     <= 1'b0;
      timeout_p1   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enabled_q    <= enabled_d;
      cfg_q        <= cfg_d;
      ill_sticky_q <= ill_sticky_d;
      tmo_sticky_q <= tmo_sticky_d;
      cls_q        <= cls_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      wb_data_q    <= wb_data_d;
      illegal_p1   <= illegal_d;
      flush_p1     <= flush_d;
      timeout_p1   <= timeout_d;
    end
  end

  tmo_limit_ok: assert property (@(posedge clk_i) TimeoutCycles >= 2);

  assign instr_ready_o = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign ga_req_o      = (state_q == ST_ISSUE);
  assign ga_cls_o      = cls_q;
  assign ga_funct3_o   = funct3_q;
  assign ga_op_a_o     = op_a_q;
  assign ga_op_b_o     = op_b_q;
  assign ga_flush_o    = flush_p1;
  assign wb_valid_o    = (state_q == ST_WB);
  assign wb_rd_o       = rd_q;
  assign wb_data_o     = wb_data_q;
  assign illegal_o     = illegal_p1;
  assign enabled_o     = enabled_q;
  assign timeout_o     = timeout_p1;

endmodule
